knight_rider_scanner: RTL and testbench

KNIGHT_RIDER_SCANNER -- requirements
Module: knight_rider_scanner

---
 rtl/knight_rider_scanner.sv | 124 ++++++++++++
 tb/tb_knight_rider_scanner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/knight_rider_scanner.sv
// Bouncing-light scanner: one lit LED walks MSB-ward then LSB-ward, one step per period.
// Define KNIGHT_RIDER_TRAIL_EN to also light the previously visited position.
module knight_rider_scanner #(
    parameter int unsigned LED_WIDTH = 8,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] period,
    output logic [LED_WIDTH-1:0] led,
    output logic                 tick,
    output logic                 dir
);

    localparam int unsigned PosW = (LED_WIDTH > 1) ? $clog2(LED_WIDTH) : 1;
    localparam logic [PosW-1:0] PosTop = PosW'(LED_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

    state_e                state_q;
    state_e                state_step;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  last_cnt;
    logic [PosW-1:0]       pos_q;
    logic [PosW-1:0]       pos_step;
    logic                  dir_step;
    logic                  started_q;
    logic                  match;
    logic [LED_WIDTH-1:0]  led_d;
`ifdef KNIGHT_RIDER_TRAIL_EN
    logic [PosW-1:0]       trail_q;
    logic                  trail_vld_q;
`endif

    // Period 0 behaves like period 1; >= lets a shrinking period match at once.
    assign last_cnt = (period == '0) ? '0 : period - CNT_WIDTH'(1);
    assign match    = (cnt_q >= last_cnt);

    always_comb begin
        pos_step   = pos_q;
        dir_step   = dir;
        state_step = state_q;
        if (state_q == StUp) begin
            if (pos_q < PosTop) begin
                pos_step = pos_q + PosW'(1);
            end else begin
                pos_step   = PosTop - PosW'(1);
                dir_step   = 1'b1;
                state_step = StDown;
            end
        end else begin
            if (pos_q > '0) begin
                pos_step = pos_q - PosW'(1);
            end else begin
                pos_step   = PosW'(1);
                dir_step   = 1'b0;
                state_step = StUp;
            end
        end
    end

    always_comb begin
        led_d = '0;
        if (started_q) begin
            led_d[pos_q] = 1'b1;
        end
`ifdef KNIGHT_RIDER_TRAIL_EN
        if (trail_vld_q) begin
            led_d[trail_q] = 1'b1;
        end
`endif
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pos_q     <= '0;
            dir       <= 1'b0;
            tick      <= 1'b0;
            led       <= '0;
            started_q <= 1'b0;
`ifdef KNIGHT_RIDER_TRAIL_EN
            trail_q     <= '0;
            trail_vld_q <= 1'b0;
`endif
        end else begin
            led  <= led_d;
            tick <= 1'b0;
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (enable) begin
                        started_q <= 1'b1;
                        state_q   <= dir ? StDown : StUp;
                    end
                end
                default: begin
                    if (!enable) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
`ifdef KNIGHT_RIDER_TRAIL_EN
                        trail_vld_q <= 1'b0;
`endif
                    end else if (match) begin
                        cnt_q   <= '0;
                        tick    <= 1'b1;
                        pos_q   <= pos_step;
                        dir     <= dir_step;
                        state_q <= state_step;
`ifdef KNIGHT_RIDER_TRAIL_EN
                        trail_q     <= pos_q;
                        trail_vld_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knight_rider_scanner.sv
// Directed and randomized checks of knight_rider_scanner against a bounce-phase model.
// Honours KNIGHT_RIDER_TRAIL_EN in the same way as the design.
module tb_knight_rider_scanner;

    localparam int N = 8;
    localparam int PHASES = 2 * N - 2;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         enable = 1'b0;
    logic [31:0]  period = 32'd4;
    logic [N-1:0] led;
    logic         tick;
    logic         dir;

    knight_rider_scanner #(.LED_WIDTH(N), .CNT_WIDTH(32)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .enable  (enable),
        .period  (period),
        .led     (led),
        .tick    (tick),
        .dir     (dir)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Model: the scan is a phase walking 0..PHASES-1 around the bounce loop.
    int           m_p = 0;
    int unsigned  m_cnt = 0;
    bit           m_run = 0;
    bit           m_started = 0;
    bit           m_dir = 0;
    int           m_trail = 0;
    bit           m_tv = 0;
    logic [N-1:0] exp_led = '0;
    bit           exp_tick = 0;

    function automatic int pos_of(input int p);
        return (p < N) ? p : PHASES - p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input logic en);
        logic [31:0] last;
        enable = en;
        @(posedge aclk);
        exp_led = m_started ? N'(1 << pos_of(m_p)) : '0;
        if (m_tv) exp_led = exp_led | N'(1 << m_trail);
        last = (period == 0) ? 32'd0 : period - 32'd1;
        exp_tick = 0;
        if (!m_run) begin
            if (en) begin
                m_run = 1;
                m_started = 1;
                m_cnt = 0;
            end
        end else if (!en) begin
            m_run = 0;
            m_cnt = 0;
            m_tv = 0;
        end else if (m_cnt >= last) begin
            exp_tick = 1;
            m_cnt = 0;
            m_trail = pos_of(m_p);
`ifdef KNIGHT_RIDER_TRAIL_EN
            m_tv = 1;
`endif
            m_p = (m_p + 1) % PHASES;
            // dir reflects the direction of the move just made
            m_dir = (m_p == 0) || (m_p >= N);
        end else begin
            m_cnt++;
        end
        #1;
        chk("tick", 32'(tick), 32'(exp_tick));
        chk("led", 32'(led), 32'(exp_led));
        chk("dir", 32'(dir), 32'(m_dir));
    endtask

    task automatic do_reset();
        #3 aresetn = 1'b0;
        #1;
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        m_p = 0; m_cnt = 0; m_run = 0; m_started = 0; m_dir = 0; m_tv = 0;
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // Advance until position k is on display with direction d.
    task automatic run_to(input int k, input bit d, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (exp_led[k] && pos_of(m_p) == k && m_dir == d && !exp_tick) return;
            cyc(1'b1);
        end
        chk(tag, 32'd0, 32'd1);
    endtask

    // Cycles from enable until the first tick, inclusive.
    task automatic cycles_to_tick(output int n);
        n = 0;
        for (int i = 1; i < 100; i++) begin
            cyc(1'b1);
            if (tick) begin
                n = i;
                return;
            end
        end
    endtask

    initial begin
        int n;
        logic [N-1:0] led0;
        #2;
        chk("por_led", 32'(led), 32'd0);
        chk("por_tick", 32'(tick), 32'd0);
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0);
        chk("idle_led_before_enable", 32'(led), 32'd0);

        // Full bounce at period 4
        period = 32'd4;
        for (int i = 0; i < 4 * 20; i++) cyc(1'b1);

        // Period 0 and 1: a tick every cycle, 14 ticks close the loop
        for (int pv = 0; pv < 2; pv++) begin
            period = 32'(pv);
            cyc(1'b1);
            led0 = led;
            n = 0;
            for (int i = 0; i < PHASES; i++) begin
                cyc(1'b1);
                n += int'(tick);
            end
            chk("fast_ticks", 32'(n), 32'(PHASES));
            chk("fast_loop_led", 32'(led), 32'(led0));
        end

        // Shrinking period below the running count
        period = 32'd10;
        for (int i = 0; i < 60 && !(m_run && m_cnt == 7); i++) cyc(1'b1);
        chk("reach_cnt7", 32'(m_cnt), 32'd7);
        period = 32'd3;
        cyc(1'b1);
        chk("shrink_tick", 32'(tick), 32'd1);
        for (int i = 0; i < 9; i++) cyc(1'b1);

        // Park while heading down at position 4, then resume
        period = 32'd4;
        run_to(4, 1'b1, "reach_down_pos4");
        for (int i = 0; i < 20; i++) cyc(1'b0);
        chk("park_led", 32'(led[4]), 32'd1);
        cycles_to_tick(n);
        chk("resume_latency", 32'(n), 32'd5);
        cyc(1'b1);
        chk("resume_pos3", 32'(led[3]), 32'd1);

        // Reset mid-scan at position 6
        run_to(6, 1'b1, "reach_pos6");
        do_reset();
        cyc(1'b1);
        cyc(1'b1);
        chk("post_reset_led", 32'(led), 32'h01);
        cycles_to_tick(n);
        chk("post_reset_latency", 32'(n), 32'd3);

        // Randomized enable / period / reset
        for (int i = 0; i < 1500; i++) begin
            if (i % 40 == 0) period = 32'($urandom_range(0, 5));
            if ($urandom_range(0, 299) == 0) do_reset();
            cyc($urandom_range(0, 11) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
